// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first, repeated
// a programmable number of times with GAP idle cycles between repetitions.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pat,
  input  logic [3:0]       reps,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX  = IW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pat;
  logic [IW-1:0]    r_bitIdx;
  logic [3:0]       r_repLeft;
  logic [3:0]       r_gapCnt;
  logic             r_dout;
  logic             r_busy;
  logic             r_done;

  state_t           w_state;
  logic [WIDTH-1:0] w_pat;
  logic [IW-1:0]    w_bitIdx;
  logic [IW-1:0]    w_bitIdxDec;
  logic [3:0]       w_repLeft;
  logic [3:0]       w_gapCnt;
  logic             w_dout;
  logic             w_busy;
  logic             w_done;

  assign w_bitIdxDec = r_bitIdx - 1'b1;

  // Outputs are computed one cycle ahead and registered, so they reflect the
  // state entered at the edge; done is simply the transition back into IDLE.
  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_bitIdx  = r_bitIdx;
    w_repLeft = r_repLeft;
    w_gapCnt  = r_gapCnt;
    w_dout    = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state   = S_SEND;
          w_pat     = pat;
          w_bitIdx  = MSB_IDX;
          w_repLeft = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
          w_dout    = pat[WIDTH-1];
          w_busy    = 1'b1;
        end
      end
      S_SEND: begin
        if (r_bitIdx != '0) begin
          w_bitIdx = w_bitIdxDec;
          w_dout   = r_pat[w_bitIdxDec];
          w_busy   = 1'b1;
        end else if (r_repLeft != 4'd0) begin
          w_repLeft = r_repLeft - 4'd1;
          w_busy    = 1'b1;
          if (GAP > 0) begin
            w_state  = S_GAP;
            w_gapCnt = GAP_LAST;
          end else begin
            w_bitIdx = MSB_IDX;
            w_dout   = r_pat[WIDTH-1];
          end
        end else begin
          w_state = S_IDLE;
          w_done  = 1'b1;
        end
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (r_gapCnt == 4'd0) begin
          w_state  = S_SEND;
          w_bitIdx = MSB_IDX;
          w_dout   = r_pat[WIDTH-1];
        end else begin
          w_gapCnt = r_gapCnt - 4'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pat     <= '0;
      r_bitIdx  <= '0;
      r_repLeft <= '0;
      r_gapCnt  <= '0;
      r_dout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pat     <= w_pat;
      r_bitIdx  <= w_bitIdx;
      r_repLeft <= w_repLeft;
      r_gapCnt  <= w_gapCnt;
      r_dout    <= w_dout;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter: WIDTH, default 8, pattern length in bits (2..16).
REQ-002 Parameter: GAP, default 2, idle cycles (dout=0) between repetitions (0..15).
REQ-003 Port: ck  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous active-low reset; sampled on rising edge of ck only.
REQ-005 Port: start  input  1  request to transmit; sampled on rising edge of ck.
REQ-006 Port: pat  input  WIDTH  pattern to send, MSB first; latched at accepted start.
REQ-007 Port: reps  input  4  repetition count, latched at accepted start; 0 treated as 1.
REQ-008 Port: dout  output  1  registered serial bit stream, one bit per ck cycle.
REQ-009 Port: busy  output  1  high while a transmission (SEND or GAP) is in progress.
REQ-010 Port: done  output  1  one-cycle pulse after final bit of final repetition.

Function
REQ-011 States SHALL be IDLE, SEND, GAP; encoding is implementation choice.
REQ-012 In IDLE: dout=0, busy=0; start=1 at edge N SHALL be accepted and latch pat, reps, reset the bit index, enter SEND.
REQ-013 First bit pat[WIDTH-1] SHALL appear on dout in the cycle after edge N (latency 1); busy=1 from that same cycle.
REQ-014 In SEND each bit SHALL be held exactly one cycle, order pat[WIDTH-1] down to pat[0]; WIDTH cycles per repetition.
REQ-015 After bit pat[0]: remaining repetitions > 0 and GAP > 0 -> GAP; remaining > 0 and GAP = 0 -> SEND directly, next repetition's MSB in the very next cycle; remaining = 0 -> IDLE.
REQ-016 In GAP: dout=0, busy=1 for exactly GAP cycles, then SEND with the same latched pattern.
REQ-017 Entry to IDLE after the last bit: done=1 for exactly that one cycle, busy=0, dout=0.
REQ-018 start SHALL be ignored while busy=1; pat and reps changes while busy SHALL have no effect.
REQ-019 start=1 in the done cycle SHALL be accepted (back-to-back jobs); next MSB appears in the following cycle.
REQ-020 Repetition counter SHALL hold reps (0 -> 1); total bits emitted = WIDTH x max(reps,1); total job cycles = WIDTH x R + GAP x (R-1).
REQ-021 Outputs SHALL be registered; no combinational path from inputs to dout, busy, done.

Reset
REQ-022 rst=0 at any edge SHALL force IDLE, dout=0, busy=0, done=0, clear counters and latched pattern on that edge.
REQ-023 rst=0 mid-SEND or mid-GAP SHALL abort with no done pulse; rst has priority over simultaneous start.
REQ-024 First accepted start SHALL be the first edge with rst=1 and start=1.

Verification
REQ-025 WIDTH=8, GAP=2, pat=8'b0110_1111, reps=1, start one cycle -> dout 0,1,1,0,1,1,1,1 over cycles 1..8 after start edge, done=1 in cycle 9, busy high cycles 1..8.
REQ-026 pat=8'hA5, reps=3, GAP=2 -> 10100101,0,0,10100101,0,0,10100101 then done; busy high for 28 cycles.
REQ-027 GAP=0, pat=8'hF0, reps=2 -> 16 contiguous bits 11110000 11110000, single done pulse cycle 17.
REQ-028 reps=0, pat=8'h81 -> exactly one repetition (10000001), done once.
REQ-029 start pulsed at cycle 3 of a job with different pat -> ignored, original stream unchanged; start in done cycle -> new job's MSB next cycle.
REQ-030 rst=0 at cycle 5 of a reps=2 job -> next cycle dout=0, busy=0, no done; rst=0 with start=1 same edge -> stays IDLE.
